// File: rtl/program_mem_arbiter_pkg.sv
// program_mem_arbiter_pkg: arbiter FSM state and registered response type
// pma_resp_t.data is PMA_DATA_W bits and must match the top's DATA_WIDTH.
package program_mem_arbiter_pkg;
  localparam int PMA_DATA_W = 32;
  typedef enum logic {ARB_CORE, ARB_DBG} arb_state_t;
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [PMA_DATA_W-1:0] data;
  } pma_resp_t;
endpackage

// File: rtl/pma_resp_reg.sv
// pma_resp_reg: one requester's registered read response
// Ports: clk, reset (async, active-low), d (next response), q (registered response).
module pma_resp_reg
  import program_mem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  pma_resp_t d,
  output pma_resp_t q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter: core/debug arbiter for a shared combinational program ROM
// Ports: clk, reset (async, active-low); core_* and dbg_* request/grant/response
// ports; rom_addr_o/rom_data_i to the ROM. Define PROGRAM_MEM_ARBITER_STARVE_GUARD_EN
// to let a starving debug request win after STARVE_LIMIT core grants;
// otherwise the core always has strict priority.
module program_mem_arbiter
  import program_mem_arbiter_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int ADDR_W      = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req_i,
  input  logic [31:0]           core_addr_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_err_o,
  input  logic                  dbg_req_i,
  input  logic [31:0]           dbg_addr_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i
);
  localparam logic [31:0] ROM_BYTES = 32'(4 * MEMORY_DEPTH);
  logic core_bad, dbg_bad, dbg_first;
  pma_resp_t core_d, core_q, dbg_d, dbg_q;
  assign core_bad = |core_addr_i[1:0] || core_addr_i >= ROM_BYTES;
  assign dbg_bad  = |dbg_addr_i[1:0] || dbg_addr_i >= ROM_BYTES;
`ifdef PROGRAM_MEM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  arb_state_t state, state_n;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
  assign dbg_first = state == ARB_DBG;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= ARB_CORE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
    end
  // Counting only happens while the core takes the ROM from a waiting debug
  // request; every other case (debug idle, debug served, ARB_DBG) restarts at 0.
  always_comb begin
    state_n      = ARB_CORE;
    starve_cnt_n = '0;
    if (state == ARB_CORE && dbg_req_i && core_gnt_o) begin
      starve_cnt_n = starve_cnt == LIMIT ? starve_cnt : starve_cnt + 1'b1;
      state_n      = starve_cnt_n == LIMIT ? ARB_DBG : ARB_CORE;
    end
  end
`else
  assign dbg_first = 1'b0;
`endif
  assign core_gnt_o = reset && core_req_i && !(dbg_first && dbg_req_i);
  assign dbg_gnt_o  = reset && dbg_req_i && !core_gnt_o;
  assign rom_addr_o = dbg_gnt_o ? dbg_addr_i[ADDR_W+1:2] : core_addr_i[ADDR_W+1:2];
  assign core_d = '{valid: core_gnt_o, err: core_gnt_o && core_bad,
                    data: core_gnt_o && !core_bad ? rom_data_i : '0};
  assign dbg_d  = '{valid: dbg_gnt_o, err: dbg_gnt_o && dbg_bad,
                    data: dbg_gnt_o && !dbg_bad ? rom_data_i : '0};
  pma_resp_reg u_core_resp (.clk(clk), .reset(reset), .d(core_d), .q(core_q));
  pma_resp_reg u_dbg_resp  (.clk(clk), .reset(reset), .d(dbg_d),  .q(dbg_q));
  assign core_rvalid_o = core_q.valid;
  assign core_err_o    = core_q.err;
  assign core_rdata_o  = core_q.data;
  assign dbg_rvalid_o  = dbg_q.valid;
  assign dbg_err_o     = dbg_q.err;
  assign dbg_rdata_o   = dbg_q.data;
endmodule

// File: tb/tb_program_mem_arbiter.sv
// tb_program_mem_arbiter: scoreboard bench for program_mem_arbiter
module tb_program_mem_arbiter;
  localparam int MD = 64;
  localparam int DW = 32;
  localparam int SL = 4;
`ifdef PROGRAM_MEM_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0;
  logic core_req = 1'b0, dbg_req = 1'b0;
  logic [31:0] core_addr = '0, dbg_addr = '0;
  logic core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [DW-1:0] core_rdata, dbg_rdata, rom_data;
  logic [5:0] rom_addr;
  logic [DW-1:0] rom [MD];
  exp_t cq[$], dq[$];
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rom_data = rom[rom_addr];
  program_mem_arbiter #(.MEMORY_DEPTH(MD), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    e  = '{0, 1'b0, 32'h0};
    ev = cq.size() > 0 && cq[0].due == cyc;
    if (ev) e = cq.pop_front();
    checks++;
    if (core_rvalid !== ev || (ev && {core_err, core_rdata} !== {e.err, e.data})) begin
      failures++;
      $display("FAIL core_resp cyc=%0d got v=%b err=%b data=%h exp v=%b err=%b data=%h",
               cyc, core_rvalid, core_err, core_rdata, ev, e.err, e.data);
    end
  end
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    e  = '{0, 1'b0, 32'h0};
    ev = dq.size() > 0 && dq[0].due == cyc;
    if (ev) e = dq.pop_front();
    checks++;
    if (dbg_rvalid !== ev || (ev && {dbg_err, dbg_rdata} !== {e.err, e.data})) begin
      failures++;
      $display("FAIL dbg_resp cyc=%0d got v=%b err=%b data=%h exp v=%b err=%b data=%h",
               cyc, dbg_rvalid, dbg_err, dbg_rdata, ev, e.err, e.data);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    core_req = 1'b1;
    dbg_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, core_err, core_rdata, dbg_rvalid, dbg_err, dbg_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_state got gnt=%b%b core v/e/d=%b/%b/%h dbg v/e/d=%b/%b/%h exp all 0",
               core_gnt, dbg_gnt, core_rvalid, core_err, core_rdata, dbg_rvalid, dbg_err, dbg_rdata);
    end
    tick();
    reset    = 1'b1;
    core_req = 1'b0;
    dbg_req  = 1'b0;
  endtask
  task automatic test_core_seq;
    for (int i = 0; i < 3; i++) begin
      tick();
      core_req  = 1'b1;
      core_addr = 32'(4 * i);
      @(negedge clk);
      checks++;
      if ({core_gnt, dbg_gnt} !== 2'b10) begin
        failures++;
        $display("FAIL core_seq_gnt i=%0d got core=%b dbg=%b exp core=1 dbg=0", i, core_gnt, dbg_gnt);
      end
      cq.push_back('{cyc + 1, 1'b0, rom[i]});
    end
    tick();
    core_req = 1'b0;
  endtask
  task automatic test_dbg_only;
    logic [31:0] addrs [2];
    logic [31:0] datas [2];
    addrs = '{32'hFC, 32'h0};
    datas = '{rom[63], rom[0]};
    for (int i = 0; i < 2; i++) begin
      tick();
      dbg_req  = 1'b1;
      dbg_addr = addrs[i];
      @(negedge clk);
      checks++;
      if ({core_gnt, dbg_gnt} !== 2'b01) begin
        failures++;
        $display("FAIL dbg_only_gnt i=%0d got core=%b dbg=%b exp core=0 dbg=1", i, core_gnt, dbg_gnt);
      end
      dq.push_back('{cyc + 1, 1'b0, datas[i]});
    end
    tick();
    dbg_req = 1'b0;
  endtask
  task automatic test_bad_addr;
    logic [31:0] addrs [3];
    logic        errs  [3];
    logic [31:0] datas [3];
    addrs = '{32'h102, 32'h100, 32'hFC};
    errs  = '{1'b1, 1'b1, 1'b0};
    datas = '{32'h0, 32'h0, rom[63]};
    for (int i = 0; i < 3; i++) begin
      tick();
      core_req  = 1'b1;
      core_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (core_gnt !== 1'b1) begin
        failures++;
        $display("FAIL bad_addr_gnt addr=%h got=%b exp=1", addrs[i], core_gnt);
      end
      cq.push_back('{cyc + 1, errs[i], datas[i]});
    end
    tick();
    core_req = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 32'h3;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1) begin
      failures++;
      $display("FAIL bad_addr_dbg_gnt got=%b exp=1", dbg_gnt);
    end
    dq.push_back('{cyc + 1, 1'b1, 32'h0});
    tick();
    dbg_req = 1'b0;
  endtask
  task automatic test_starve(input int n);
    logic exp_d;
    for (int k = 0; k < n; k++) begin
      tick();
      core_req  = 1'b1;
      core_addr = 32'(4 * k);
      dbg_req   = 1'b1;
      dbg_addr  = 32'h40;
      @(negedge clk);
      exp_d = GUARD && (k % (SL + 1) == SL);
      checks++;
      if ({core_gnt, dbg_gnt} !== {!exp_d, exp_d}) begin
        failures++;
        $display("FAIL starve_gnt k=%0d got core=%b dbg=%b exp core=%b dbg=%b",
                 k, core_gnt, dbg_gnt, !exp_d, exp_d);
      end
      if (exp_d) dq.push_back('{cyc + 1, 1'b0, rom[16]});
      else cq.push_back('{cyc + 1, 1'b0, rom[k]});
    end
    tick();
    core_req = 1'b0;
    dbg_req  = 1'b0;
  endtask
  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      tick();
      core_req  = 1'b1;
      core_addr = 32'(4 * k);
      dbg_req   = 1'b1;
      dbg_addr  = 32'h40;
      @(negedge clk);
      checks++;
      if ({core_gnt, dbg_gnt} !== 2'b10) begin
        failures++;
        $display("FAIL mid_prefix_gnt k=%0d got core=%b dbg=%b exp core=1 dbg=0", k, core_gnt, dbg_gnt);
      end
      cq.push_back('{cyc + 1, 1'b0, rom[k]});
    end
    tick();
    reset = 1'b0;
    cq.delete();
    dq.delete();
    #1;
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid, core_err, core_rdata, dbg_rvalid, dbg_err, dbg_rdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset got gnt=%b%b core v/e/d=%b/%b/%h dbg v/e/d=%b/%b/%h exp all 0",
               core_gnt, dbg_gnt, core_rvalid, core_err, core_rdata, dbg_rvalid, dbg_err, dbg_rdata);
    end
    tick();
    reset    = 1'b1;
    core_req = 1'b0;
    dbg_req  = 1'b0;
    test_starve(6);
  endtask
  initial begin
    for (int i = 0; i < MD; i++) rom[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
    test_reset();
    test_core_seq();
    test_dbg_only();
    test_bad_addr();
    test_starve(10);
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (cq.size() + dq.size() != 0) begin
      failures++;
      $display("FAIL drain got pending core=%0d dbg=%0d exp 0", cq.size(), dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_mem_arbiter.md
PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

Interface
REQ-001 Parameter MEMORY_DEPTH, default 64, SHALL be the number of DATA_WIDTH words in the shared program ROM.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the instruction word width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL be the maximum number of consecutive core grants while a debug request waits.
REQ-004 Localparam ADDR_W = $clog2(MEMORY_DEPTH) SHALL set the word-index width.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be asynchronous, active-low; the block resets while reset==0.
REQ-007 core_req_i  input  1  SHALL be the core fetch request, held until granted.
REQ-008 core_addr_i  input  32  SHALL be the core byte address, held with core_req_i.
REQ-009 core_gnt_o  output  1  SHALL be the combinational core grant.
REQ-010 core_rvalid_o / core_rdata_o / core_err_o  output  1/DATA_WIDTH/1  SHALL be the registered core response.
REQ-011 dbg_req_i, dbg_addr_i (32), dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o SHALL mirror the core port for the debug reader.
REQ-012 rom_addr_o  output  ADDR_W  SHALL drive the combinational ROM word address.
REQ-013 rom_data_i  input  DATA_WIDTH  SHALL be the combinational ROM read data.

Function
REQ-014 At most one grant SHALL be asserted per cycle; a grant is only asserted while its request is high.
REQ-015 Default priority: the core SHALL win when both requests are high.
REQ-016 rom_addr_o SHALL equal addr[ADDR_W+1:2] of the granted requester, or of core_addr_i when neither is granted.
REQ-017 Read latency: rvalid SHALL assert exactly one cycle after the grant, for one cycle, with rdata = rom_data_i captured at the grant edge.
REQ-018 Back-to-back grants to the same requester SHALL produce rvalid on consecutive cycles.
REQ-019 An address with addr[1:0]!=0 or addr >= 4*MEMORY_DEPTH SHALL still be granted; its response SHALL carry err=1 and rdata=0.
REQ-020 FSM states: ARB_CORE (core priority) and ARB_DBG (debug forced).
REQ-021 In ARB_CORE, counter starve_cnt SHALL increment on each cycle with core granted and dbg_req_i high, clear when dbg_req_i is low, and on reaching STARVE_LIMIT move to ARB_DBG.
REQ-022 In ARB_DBG, a pending debug request SHALL be granted over the core; after that grant, or if dbg_req_i drops, the FSM SHALL return to ARB_CORE with starve_cnt=0.
REQ-023 starve_cnt SHALL saturate at STARVE_LIMIT and never wrap.
REQ-024 Responses of a requester SHALL never appear on the other requester's rvalid/rdata/err.

Reset
REQ-025 While reset==0: FSM=ARB_CORE, starve_cnt=0, all rvalid=0, all rdata=0, all err=0; grants forced to 0.
REQ-026 A grant issued in the cycle reset asserts SHALL produce no response after reset release.

Configuration
REQ-027 With macro PROGRAM_MEM_ARBITER_STARVE_GUARD_EN defined, REQ-021..REQ-023 SHALL apply.
REQ-028 Without PROGRAM_MEM_ARBITER_STARVE_GUARD_EN, the FSM and counter SHALL be absent and the core SHALL always win (strict priority).

Structure
REQ-029 A shared package SHALL hold the FSM state enum (ARB_CORE, ARB_DBG) and the response struct {valid, err, data}.
REQ-030 One sub-module, pma_resp_reg, SHALL implement the per-requester response register (instantiated twice).

Verification
REQ-031 Core only, core_addr_i=0x0,0x4,0x8 consecutive -> gnt each cycle, rvalid next cycles with rom[0],rom[1],rom[2].
REQ-032 Debug only, dbg_addr_i=0xFC, MEMORY_DEPTH=64 -> dbg_rvalid=1, dbg_rdata=rom[63], dbg_err=0.
REQ-033 Both requesting continuously, guard enabled -> pattern 4 core grants, 1 debug grant, repeating; guard disabled -> debug never granted.
REQ-034 core_addr_i=0x102 then 0x100 -> both granted; responses err=1, rdata=0.
REQ-035 reset driven low mid-stream with starve_cnt=3 -> rvalid/err/rdata=0 immediately; after release, first dual request grants core and starve_cnt restarts from 0.
